// File: rtl/strawman_tx_fsm.sv
// strawman_tx_fsm: transmit packetiser. Turns one request handshake plus a
// payload word stream into a sequence of 40-bit flits (lightweight or
// extended header format) written into the TX flit FIFO.
module strawman_tx_fsm #(
  parameter int DATA_LINE_WIDTH = 40,
  parameter int WORD_SIZE       = 32,
  parameter int LOG2_NUM_STATES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_ext,
  input  logic [2:0]                 i_cmd,
  input  logic [2:0]                 i_length,
  input  logic [WORD_SIZE-1:0]       i_address,
  input  logic [5:0]                 i_feature1,
  input  logic [5:0]                 i_feature2,
  input  logic [WORD_SIZE-1:0]       i_data,
  input  logic                       i_data_valid,
  output logic                       o_data_ready,
  input  logic                       i_tx_full,
  output logic                       o_tx_wen,
  output logic [DATA_LINE_WIDTH-1:0] o_flit,
  output logic                       o_err
);

  localparam logic [2:0] CMD_RD_REQ  = 3'b000;
  localparam logic [2:0] CMD_WR_REQ  = 3'b001;
  localparam logic [2:0] CMD_RD_RESP = 3'b010;
  localparam logic [2:0] MAX_LENGTH  = 3'd5;
  localparam int         PAD_W       = DATA_LINE_WIDTH - WORD_SIZE;

  typedef enum logic [LOG2_NUM_STATES-1:0] {
    IDLE,
    HEADER,
    EX_WORD,
    BODY
  } state_e;

  state_e                      state_q, state_d;
  logic                        ext_q, ext_d;
  logic [2:0]                  cmd_q, cmd_d;
  logic [2:0]                  len_q, len_d;
  logic [WORD_SIZE-1:0]        addr_q, addr_d;
  logic [5:0]                  f1_q, f1_d;
  logic [5:0]                  f2_q, f2_d;
  logic [5:0]                  cnt_q, cnt_d;
  logic                        wen_q, wen_d;
  logic [DATA_LINE_WIDTH-1:0]  flit_q, flit_d;
  logic                        err_q, err_d;

  logic                        req_ready;
  logic                        data_ready;
  logic                        lw_rresp;
  logic [5:0]                  n_words;
  logic [7:0]                  hdr_low;
  logic [DATA_LINE_WIDTH-1:0]  hdr_flit;
  logic [DATA_LINE_WIDTH-1:0]  word_flit;

  // State, latched request and registered FIFO-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ext_q   <= 1'b0;
      cmd_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      f1_q    <= '0;
      f2_q    <= '0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      flit_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      flit_q  <= flit_d;
      err_q   <= err_d;
    end
  end

  // Flit formatting for the latched request
  always_comb begin
    lw_rresp = !ext_q && (cmd_q == CMD_RD_RESP);
    n_words  = 6'd1 << len_q;
    hdr_low  = {len_q, cmd_q, 1'b1, ext_q};
    if (ext_q) begin
      hdr_flit = {20'd0, f2_q, f1_q, hdr_low};
    end else if (lw_rresp) begin
      hdr_flit = {i_data, hdr_low};
    end else begin
      hdr_flit = {addr_q, hdr_low};
    end
    word_flit = {{PAD_W{1'b0}}, i_data};
  end

  // Next-state, emission and handshake logic
  always_comb begin
    state_d    = state_q;
    ext_d      = ext_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    addr_d     = addr_q;
    f1_d       = f1_q;
    f2_d       = f2_q;
    cnt_d      = cnt_q;
    wen_d      = 1'b0;
    flit_d     = flit_q;
    err_d      = 1'b0;
    req_ready  = 1'b0;
    data_ready = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (i_req_valid) begin
          if ((i_cmd > CMD_RD_RESP) || (i_length > MAX_LENGTH)) begin
            err_d = 1'b1;
          end else begin
            ext_d   = i_ext;
            cmd_d   = i_cmd;
            len_d   = i_length;
            addr_d  = i_address;
            f1_d    = i_feature1;
            f2_d    = i_feature2;
            state_d = HEADER;
          end
        end
      end

      HEADER: begin
        // A lightweight read response carries payload word 0 in its header
        data_ready = lw_rresp && !i_tx_full;
        if (!i_tx_full && (!lw_rresp || i_data_valid)) begin
          wen_d  = 1'b1;
          flit_d = hdr_flit;
          if (ext_q) begin
            if (cmd_q == CMD_RD_RESP) begin
              cnt_d   = n_words;
              state_d = BODY;
            end else begin
              state_d = EX_WORD;
            end
          end else if (cmd_q == CMD_WR_REQ) begin
            cnt_d   = n_words;
            state_d = BODY;
          end else if (lw_rresp && (n_words != 6'd1)) begin
            cnt_d   = n_words - 6'd1;
            state_d = BODY;
          end else begin
            state_d = IDLE;
          end
        end
      end

      EX_WORD: begin
        if (!i_tx_full) begin
          wen_d  = 1'b1;
          flit_d = {{PAD_W{1'b0}}, addr_q};
          if (cmd_q == CMD_WR_REQ) begin
            cnt_d   = n_words;
            state_d = BODY;
          end else begin
            state_d = IDLE;
          end
        end
      end

      BODY: begin
        data_ready = !i_tx_full;
        if (!i_tx_full && i_data_valid) begin
          wen_d  = 1'b1;
          flit_d = word_flit;
          cnt_d  = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request ready is held low while reset is asserted
  always_comb begin
    o_req_ready  = req_ready && rst_n;
    o_data_ready = data_ready;
    o_tx_wen     = wen_q;
    o_flit       = flit_q;
    o_err        = err_q;
  end

endmodule

// File: tb/tb_strawman_tx_fsm.sv
// Self-checking bench for strawman_tx_fsm: expected flits and payload words
// are queued when a request is issued and matched as the DUT writes flits.
module tb_strawman_tx_fsm;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_ext;
  logic [2:0]  i_cmd;
  logic [2:0]  i_length;
  logic [31:0] i_address;
  logic [5:0]  i_feature1;
  logic [5:0]  i_feature2;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic        i_tx_full;
  logic        o_tx_wen;
  logic [39:0] o_flit;
  logic        o_err;

  logic [39:0] exp_q[$];
  logic [31:0] data_q[$];
  int          n_cmp;
  int          n_err;
  int          wen_seen;
  int          err_cnt;
  bit          saw_dready;
  bit          toggle_mode;
  bit          prev_full;
  bit          consumed;
  bit          phase;

  strawman_tx_fsm #(
    .DATA_LINE_WIDTH(40),
    .WORD_SIZE(32),
    .LOG2_NUM_STATES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_ext(i_ext),
    .i_cmd(i_cmd),
    .i_length(i_length),
    .i_address(i_address),
    .i_feature1(i_feature1),
    .i_feature2(i_feature2),
    .i_data(i_data),
    .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready),
    .i_tx_full(i_tx_full),
    .o_tx_wen(o_tx_wen),
    .o_flit(o_flit),
    .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload source: presents the head of data_q, pops it once consumed
  initial begin
    i_data_valid = 1'b0;
    i_data       = '0;
    forever begin
      @(negedge clk);
      consumed = i_data_valid && o_data_ready && rst_n;
      @(posedge clk);
      #1;
      if (consumed && data_q.size() > 0) void'(data_q.pop_front());
      phase = ~phase;
      if (data_q.size() > 0 && (!toggle_mode || phase)) begin
        i_data_valid = 1'b1;
        i_data       = data_q[0];
      end else begin
        i_data_valid = 1'b0;
      end
    end
  end

  // Flit monitor: every write must match the next expected flit
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_data_ready) saw_dready = 1'b1;
      if (o_err) err_cnt++;
      if (prev_full) begin
        n_cmp++;
        if (o_tx_wen !== 1'b0) begin
          n_err++;
          $display("FAIL wen_while_full: got wen=%b want 0", o_tx_wen);
        end
      end
      if (o_tx_wen) begin
        wen_seen++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_flit: got %h want no write", o_flit);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          if (o_flit !== e) begin
            n_err++;
            $display("FAIL flit: got %h want %h", o_flit, e);
          end
        end
      end
      prev_full = i_tx_full;
    end else begin
      prev_full = 1'b0;
    end
  end

  task automatic send_req(input logic ext, input logic [2:0] cmd, input logic [2:0] len,
                          input logic [31:0] addr, input logic [5:0] f1, input logic [5:0] f2);
    @(posedge clk);
    #1;
    i_ext = ext; i_cmd = cmd; i_length = len; i_address = addr;
    i_feature1 = f1; i_feature2 = f2; i_req_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL req_ready: got %b want 1", o_req_ready);
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d flits outstanding want 0", name, exp_q.size());
    end
    @(negedge clk);
    n_cmp++;
    if (o_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_idle: got req_ready=%b want 1", name, o_req_ready);
    end
  endtask

  task automatic wait_wen(input int target, input string name);
    int i;
    for (i = 0; i < 300 && wen_seen < target; i++) @(negedge clk);
    if (wen_seen < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d writes want %0d", name, wen_seen, target);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({o_tx_wen, o_flit, o_err, o_req_ready, o_data_ready} !== 44'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got wen=%b flit=%h err=%b rdy=%b drdy=%b want all 0",
               o_tx_wen, o_flit, o_err, o_req_ready, o_data_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_req_ready !== 1'b1 || o_tx_wen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b wen=%b want 1 0", o_req_ready, o_tx_wen);
    end
  endtask

  task automatic test_lw_write();
    exp_q.push_back(40'hDEADBEEF26);
    exp_q.push_back(40'h0011111111);
    exp_q.push_back(40'h0022222222);
    data_q.push_back(32'h11111111);
    data_q.push_back(32'h22222222);
    send_req(1'b0, 3'b001, 3'd1, 32'hDEADBEEF, 6'd0, 6'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_tx_wen !== 1'b1) begin
        n_err++;
        $display("FAIL lw_write_consecutive[%0d]: got wen=%b want 1", i, o_tx_wen);
      end
    end
    wait_drain("lw_write");
  endtask

  task automatic test_ex_read_req();
    saw_dready = 1'b0;
    exp_q.push_back(40'h0000028543);
    exp_q.push_back(40'h0000001000);
    send_req(1'b1, 3'b000, 3'd2, 32'h00001000, 6'h05, 6'h0A);
    wait_drain("ex_read_req");
    n_cmp++;
    if (saw_dready !== 1'b0) begin
      n_err++;
      $display("FAIL ex_read_req_dready: got data_ready seen=%b want 0", saw_dready);
    end
  endtask

  task automatic test_lw_read_resp();
    logic [31:0] w[4];
    w[0] = 32'hA1A2A3A4; w[1] = 32'hB1B2B3B4; w[2] = 32'hC1C2C3C4; w[3] = 32'hD1D2D3D4;
    exp_q.push_back({w[0], 8'h4A});
    for (int i = 0; i < 4; i++) data_q.push_back(w[i]);
    for (int i = 1; i < 4; i++) exp_q.push_back({8'h00, w[i]});
    send_req(1'b0, 3'b010, 3'd2, 32'h0, 6'd0, 6'd0);
    wait_drain("lw_read_resp");
  endtask

  task automatic test_backpressure();
    int base;
    base = wen_seen;
    toggle_mode = 1'b1;
    exp_q.push_back({32'hCAFE0000, 8'h66});
    for (int i = 0; i < 8; i++) begin
      data_q.push_back(32'hB0000000 + i);
      exp_q.push_back({8'h00, 32'hB0000000 + i});
    end
    send_req(1'b0, 3'b001, 3'd3, 32'hCAFE0000, 6'd0, 6'd0);
    wait_wen(base + 3, "backpressure");
    @(posedge clk);
    #1;
    i_tx_full = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_tx_full = 1'b0;
    wait_drain("backpressure");
    toggle_mode = 1'b0;
    n_cmp++;
    if (data_q.size() != 0 || wen_seen != base + 9) begin
      n_err++;
      $display("FAIL backpressure_count: got writes=%0d words_left=%0d want 9 0",
               wen_seen - base, data_q.size());
    end
  endtask

  task automatic test_invalid(input logic [2:0] cmd, input logic [2:0] len, input string name);
    int base;
    base    = wen_seen;
    err_cnt = 0;
    send_req(1'b0, cmd, len, 32'h55555555, 6'd0, 6'd0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (err_cnt != 1 || wen_seen != base) begin
      n_err++;
      $display("FAIL %s: got err_cycles=%0d writes=%0d want 1 0", name, err_cnt, wen_seen - base);
    end
  endtask

  task automatic test_reset_mid_packet();
    int base;
    base = wen_seen;
    exp_q.push_back({32'h0BADF00D, 8'h66});
    for (int i = 0; i < 8; i++) begin
      data_q.push_back(32'hE0000000 + i);
      exp_q.push_back({8'h00, 32'hE0000000 + i});
    end
    send_req(1'b0, 3'b001, 3'd3, 32'h0BADF00D, 6'd0, 6'd0);
    wait_wen(base + 2, "reset_mid");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_tx_wen !== 1'b0 || o_flit !== 40'd0 || o_req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got wen=%b flit=%h rdy=%b want 0 0 0",
               o_tx_wen, o_flit, o_req_ready);
    end
    exp_q.delete();
    data_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({32'h12345678, 8'h02});
    send_req(1'b0, 3'b000, 3'd0, 32'h12345678, 6'd0, 6'd0);
    wait_drain("reset_recover");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0; wen_seen = 0; err_cnt = 0;
    saw_dready = 1'b0; toggle_mode = 1'b0; prev_full = 1'b0; phase = 1'b0;
    rst_n = 1'b0; i_req_valid = 1'b0; i_ext = 1'b0; i_cmd = '0; i_length = '0;
    i_address = '0; i_feature1 = '0; i_feature2 = '0; i_tx_full = 1'b0;
    test_reset();
    test_lw_write();
    test_ex_read_req();
    test_lw_read_resp();
    test_backpressure();
    test_invalid(3'b011, 3'd1, "invalid_cmd");
    test_invalid(3'b001, 3'd6, "invalid_len");
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
